// File: rtl/game_round_scheduler_pkg.sv
// rtl/game_round_scheduler_pkg.sv - shared state encoding, widths and helpers for the round scheduler
//
// Purpose: one-hot state indices and state type, fixed field widths and the
//          default speed base used by game_round_scheduler.
// Ports:   none (package).

package game_round_scheduler_pkg;

    localparam int LEVEL_W            = 3;
    localparam int LIVES_W            = 3;
    localparam int SPEED_W            = 4;
    localparam int SPEED_BASE_DEFAULT = 1;
    localparam int LIVES_CAP          = 7;

    // One-hot bit positions; the enum values below are built from these.
    localparam int ST_IDLE      = 0;
    localparam int ST_PLAY      = 1;
    localparam int ST_ROUND_END = 2;
    localparam int ST_RESULT    = 3;
    localparam int ST_OVER      = 4;
    localparam int NUM_STATES   = 5;

    typedef enum logic [NUM_STATES-1:0] {
        S_IDLE      = 5'b00001 << ST_IDLE,
        S_PLAY      = 5'b00001 << ST_PLAY,
        S_ROUND_END = 5'b00001 << ST_ROUND_END,
        S_RESULT    = 5'b00001 << ST_RESULT,
        S_OVER      = 5'b00001 << ST_OVER
    } state_t;

    // Increment a 3-bit field, holding at ceiling.
    function automatic logic [2:0] sat_inc3(input logic [2:0] value, input logic [2:0] ceiling);
        return (value >= ceiling) ? ceiling : value + 3'd1;
    endfunction

endpackage

// File: rtl/game_key_edge.sv
// rtl/game_key_edge.sv - key delay register and rising-edge pulse
//
// Purpose: registers a debounced key level and flags the cycle on which it
//          goes from low to high.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   key       in  debounced key level
//   key_rise  out key & ~key_q (combinational, one cycle wide)

module game_key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic key_rise
);

    logic key_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    assign key_rise = key & ~key_q;

endmodule

// File: rtl/game_round_scheduler.sv
// rtl/game_round_scheduler.sv - campaign sequencer above the game master: rounds, score, lives, level
//
// Purpose: holds the game master in reset between campaigns, forwards the key
//          while a round is in play, judges each finished round and keeps
//          score / lives / level / target speed.
// Option:  GAME_ROUND_SCHEDULER_BONUS_LIFE_EN - each level-up also grants a
//          life (saturating at 7).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   key                  debounced fire/start key level
//   master_reset         out, holds the game master in reset while high
//   master_key           out, key forwarded to the game master
//   round_end            in, master end-of-game timer start pulse
//   round_won            in, master game_won
//   round_timer_running  in, master end-of-game timer running
//   score                out, rounds won this campaign (saturating)
//   lives                out, remaining lives
//   level                out, current level
//   target_speed         out, SPEED_BASE + level, one cycle behind level
//   campaign_over        out, high while in OVER

module game_round_scheduler
    import game_round_scheduler_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int SCORE_W        = 8,
    parameter int HITS_PER_LEVEL = 4,
    parameter int LEVEL_MAX      = 7,
    parameter int SPEED_BASE     = SPEED_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key,
    output logic               master_reset,
    output logic               master_key,
    input  logic               round_end,
    input  logic               round_won,
    input  logic               round_timer_running,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level,
    output logic [SPEED_W-1:0] target_speed,
    output logic               campaign_over
);

    localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(LEVEL_MAX);
    localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HITS_PER_LEVEL - 1);

    state_t state, state_next;

    logic               key_rise;
    logic [HIT_W-1:0]   hit_cnt, hit_next;
    logic               won_q, won_next;
    logic [SCORE_W-1:0] score_next;
    logic [LIVES_W-1:0] lives_next;
    logic [LEVEL_W-1:0] level_next;
    logic               master_reset_next;
    logic               master_key_next;
    logic               over_next;

    game_key_edge u_key_edge (
        .clk      (clk),
        .reset    (reset),
        .key      (key),
        .key_rise (key_rise)
    );

    // Outputs are registered from the current state, so master_reset and
    // campaign_over trail the state register by one cycle.
    always_comb begin
        state_next        = state;
        score_next        = score;
        lives_next        = lives;
        level_next        = level;
        hit_next          = hit_cnt;
        won_next          = won_q;
        master_reset_next = 1'b1;
        master_key_next   = 1'b0;
        over_next         = 1'b0;

        unique case (state)
            S_IDLE: begin
                // The starting key press is consumed here, never forwarded.
                if (key_rise) begin
                    score_next = '0;
                    hit_next   = '0;
                    level_next = '0;
                    lives_next = LIVES_INIT;
                    state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                master_reset_next = 1'b0;
                master_key_next   = key;
                if (round_end) begin
                    state_next = S_ROUND_END;
                end
            end
            S_ROUND_END: begin
                // game_won may still set during the master END state, so the
                // verdict is taken only once the end timer has stopped.
                master_reset_next = 1'b0;
                if (!round_timer_running) begin
                    won_next   = round_won;
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                master_reset_next = 1'b0;
                if (won_q) begin
                    score_next = (&score) ? score : score + SCORE_W'(1);
                    if (hit_cnt == HIT_LAST) begin
                        hit_next = '0;
                        if (level != LEVEL_TOP) begin
                            level_next = sat_inc3(level, LEVEL_TOP);
`ifdef GAME_ROUND_SCHEDULER_BONUS_LIFE_EN
                            lives_next = sat_inc3(lives, 3'(LIVES_CAP));
`endif
                        end
                    end else begin
                        hit_next = hit_cnt + HIT_W'(1);
                    end
                    state_next = S_PLAY;
                end else begin
                    lives_next = (lives == '0) ? lives : lives - LIVES_W'(1);
                    state_next = (lives <= LIVES_W'(1)) ? S_OVER : S_PLAY;
                end
            end
            S_OVER: begin
                over_next = 1'b1;
                if (key_rise) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            score         <= '0;
            lives         <= LIVES_INIT;
            level         <= '0;
            hit_cnt       <= '0;
            won_q         <= 1'b0;
            master_reset  <= 1'b1;
            master_key    <= 1'b0;
            campaign_over <= 1'b0;
            target_speed  <= SPEED_W'(SPEED_BASE);
        end else begin
            state         <= state_next;
            score         <= score_next;
            lives         <= lives_next;
            level         <= level_next;
            hit_cnt       <= hit_next;
            won_q         <= won_next;
            master_reset  <= master_reset_next;
            master_key    <= master_key_next;
            campaign_over <= over_next;
            // Follows the registered level, hence one cycle behind it.
            target_speed  <= SPEED_W'(SPEED_BASE) + SPEED_W'(level);
        end
    end

endmodule
